bw_io_impctl_deser: RTL and testbench

Receive-side counterpart of the impedance-control serial clock/shift path. Runs on l2clk and samples a serial impedance-code stream once per divided-clock strobe (sclk_en, one l2clk cycle wide, once per 16 l2clk cycles). Deserializes framed codes, checks parity and stop bit, and presents each code to pad drive logic with a valid/ready handshake. Sits in the pad ring, downstream of the impedance controller's serial output.

---
 rtl/bw_io_impctl_pkg.sv | 21 ++
 rtl/bw_io_impctl_sync2.sv | 25 ++
 rtl/bw_io_impctl_deser.sv | 152 +++++++++++++++
 tb/tb_bw_io_impctl_deser.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bw_io_impctl_pkg.sv
// Shared types and helpers for the impedance-control serial code path.
// Holds the frame FSM encoding, default code width and the parity helper.
package bw_io_impctl_pkg;

  localparam int IMPCTL_CODE_W_DEF = 8;
  localparam int IMPCTL_CNT_W      = 4;
  localparam int IMPCTL_PAR_W      = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } impctl_state_e;

  // Callers zero-extend narrower codes; the padding bits leave the XOR unchanged.
  function automatic logic impctl_parity(input logic [IMPCTL_PAR_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/bw_io_impctl_sync2.sv
// Two-flop synchronizer for slow pad-side control inputs.
// Resets to 1 so that a serial line idling high reads as idle straight after reset.
module bw_io_impctl_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bw_io_impctl_deser.sv
// Impedance-code deserializer: start/data/parity/stop framing with a valid/ready output.
// Optional build macro IMPCTL_DESER_MAJ_FILTER_EN adds a 3-sample majority glitch filter on si.
module bw_io_impctl_deser
  import bw_io_impctl_pkg::*;
#(
  parameter int CODE_W  = IMPCTL_CODE_W_DEF,
  parameter bit ODD_PAR = 1'b1
) (
  input  logic              l2clk,
  input  logic              global_reset,
  input  logic              sclk_en,
  input  logic              si,
  output logic [CODE_W-1:0] code_out,
  output logic              code_vld,
  input  logic              code_rdy,
  output logic              par_err,
  output logic              frm_err,
  output logic              ovr_err,
  output logic              busy
);

  localparam logic [IMPCTL_CNT_W-1:0] CNT_LAST = IMPCTL_CNT_W'(CODE_W - 1);

  logic sync_si;
  logic si_s;

  impctl_state_e           state_q,   state_d;
  logic [IMPCTL_CNT_W-1:0] cnt_q,     cnt_d;
  logic [CODE_W-1:0]       shift_q,   shift_d;
  logic                    bad_q,     bad_d;
  logic [CODE_W-1:0]       code_q,    code_d;
  logic                    vld_q,     vld_d;
  logic                    par_err_q, par_err_d;
  logic                    frm_err_q, frm_err_d;
  logic                    ovr_err_q, ovr_err_d;
  logic                    deliver;

  bw_io_impctl_sync2 u_sync (
    .clk_i (l2clk),
    .rst_i (global_reset),
    .d_i   (si),
    .q_o   (sync_si)
  );

`ifdef IMPCTL_DESER_MAJ_FILTER_EN
  logic [2:0] hist_q;

  // A lone bad sample in the last three cycles is outvoted by the other two.
  always_ff @(posedge l2clk) begin
    if (global_reset) begin
      hist_q <= 3'b111;
    end else begin
      hist_q <= {hist_q[1:0], sync_si};
    end
  end

  assign si_s = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
`else
  assign si_s = sync_si;
`endif

  always_ff @(posedge l2clk) begin
    if (global_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      bad_q     <= 1'b0;
      code_q    <= '0;
      vld_q     <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bad_q     <= bad_d;
      code_q    <= code_d;
      vld_q     <= vld_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovr_err_q <= ovr_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bad_d     = bad_q;
    code_d    = code_q;
    vld_d     = vld_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    ovr_err_d = ovr_err_q;
    deliver   = 1'b0;

    if (sclk_en) begin
      unique case (state_q)
        IDLE: begin
          if (!si_s) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d = {si_s, shift_q[CODE_W-1:1]};
          if (cnt_q == CNT_LAST) begin
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          bad_d   = (impctl_parity(IMPCTL_PAR_W'(shift_q)) ^ si_s) != ODD_PAR;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!si_s) begin
            frm_err_d = 1'b1;
          end else if (bad_q) begin
            par_err_d = 1'b1;
          end else begin
            deliver = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A pending code that is not being taken wins over the new one.
    if (deliver) begin
      if (vld_q && !code_rdy) begin
        ovr_err_d = 1'b1;
      end else begin
        code_d = shift_q;
        vld_d  = 1'b1;
      end
    end else if (vld_q && code_rdy) begin
      vld_d = 1'b0;
    end
  end

  assign code_out = code_q;
  assign code_vld = vld_q;
  assign par_err  = par_err_q;
  assign frm_err  = frm_err_q;
  assign ovr_err  = ovr_err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_bw_io_impctl_deser.sv
// Self-checking bench for bw_io_impctl_deser: directed frames plus randomized frames vs. a frame-level model.
module tb_bw_io_impctl_deser;

  logic       l2clk = 1'b0;
  logic       global_reset;
  logic       sclk_en;
  logic       si;
  logic       code_rdy;
  logic [7:0] code_out;
  logic       code_vld;
  logic       par_err;
  logic       frm_err;
  logic       ovr_err;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] expCode = 8'h00;
  bit         expVld  = 1'b0;
  bit         expPar  = 1'b0;
  bit         expFrm  = 1'b0;
  bit         expOvr  = 1'b0;
  bit         rdyIdle = 1'b0;

  always #5 l2clk = ~l2clk;

  bw_io_impctl_deser #(
    .CODE_W  (8),
    .ODD_PAR (1'b1)
  ) dut (
    .l2clk        (l2clk),
    .global_reset (global_reset),
    .sclk_en      (sclk_en),
    .si           (si),
    .code_out     (code_out),
    .code_vld     (code_vld),
    .code_rdy     (code_rdy),
    .par_err      (par_err),
    .frm_err      (frm_err),
    .ovr_err      (ovr_err),
    .busy         (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".vld"},  32'(code_vld), 32'(expVld));
    checkOutput({tag, ".code"}, 32'(code_out), 32'(expCode));
    checkOutput({tag, ".par"},  32'(par_err),  32'(expPar));
    checkOutput({tag, ".frm"},  32'(frm_err),  32'(expFrm));
    checkOutput({tag, ".ovr"},  32'(ovr_err),  32'(expOvr));
  endtask

  // Advances one l2clk edge, updating the handshake model for that edge first.
  task automatic clockEdge(input bit dlv, input logic [7:0] dlvCode);
    if (global_reset) begin
      expVld  = 1'b0;
      expCode = 8'h00;
      expPar  = 1'b0;
      expFrm  = 1'b0;
      expOvr  = 1'b0;
    end else if (dlv) begin
      if (expVld && !code_rdy) begin
        expOvr = 1'b1;
      end else begin
        expCode = dlvCode;
        expVld  = 1'b1;
      end
    end else if (expVld && code_rdy) begin
      expVld = 1'b0;
    end
    @(posedge l2clk);
    #1;
  endtask

  task automatic applyReset();
    global_reset = 1'b1;
    sclk_en      = 1'b0;
    clockEdge(1'b0, 8'h00);
    global_reset = 1'b0;
  endtask

  // One strobe period: 15 quiet cycles, then the sampling strobe. A glitch drives
  // the opposite level for one cycle timed to reach the synchronizer output at the strobe.
  task automatic sendBit(input logic b, input bit glitch, input bit rdyS, input bit dlv,
                         input logic [7:0] c);
    si       = b;
    code_rdy = rdyIdle;
    sclk_en  = 1'b0;
    if (glitch) begin
      repeat (13) clockEdge(1'b0, 8'h00);
      si = ~b;
      clockEdge(1'b0, 8'h00);
      si = b;
      clockEdge(1'b0, 8'h00);
    end else begin
      repeat (15) clockEdge(1'b0, 8'h00);
    end
    sclk_en  = 1'b1;
    code_rdy = rdyS;
    clockEdge(dlv, c);
    sclk_en  = 1'b0;
    code_rdy = rdyIdle;
  endtask

  // Sends a whole frame; glitchIdx selects a data bit to glitch (-1 for none).
  task automatic applyStimulus(input logic [7:0] data, input bit parGood, input bit stopGood,
                               input bit stopRdy, input int glitchIdx);
    logic parBit;
    parBit = ($countones(data) % 2 == 0);
    if (!parGood) parBit = ~parBit;
    sendBit(1'b0, 1'b0, rdyIdle, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) sendBit(data[i], (i == glitchIdx), rdyIdle, 1'b0, 8'h00);
    sendBit(parBit, 1'b0, rdyIdle, 1'b0, 8'h00);
    if (!stopGood) expFrm = 1'b1;
    else if (!parGood) expPar = 1'b1;
    sendBit(stopGood, 1'b0, stopRdy, parGood && stopGood, data);
    si = 1'b1;
  endtask

  initial begin
    global_reset = 1'b1;
    sclk_en      = 1'b0;
    si           = 1'b1;
    code_rdy     = 1'b0;
    applyReset();
    applyReset();
    checkAll("reset");
    checkOutput("reset.busy", 32'(busy), 32'd0);

    // Idle strobe with the line high must not start a frame.
    sendBit(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("idle.busy", 32'(busy), 32'd0);

    // Basic good frame with the consumer always ready.
    rdyIdle = 1'b1;
    applyStimulus(8'hA5, 1'b1, 1'b1, 1'b1, -1);
    checkAll("basic");
    checkOutput("basic.busy", 32'(busy), 32'd0);
    clockEdge(1'b0, 8'h00);
    checkOutput("basic.pulse", 32'(code_vld), 32'(expVld));

    // Parity error is sticky across a later good frame.
    applyStimulus(8'hA5, 1'b0, 1'b1, 1'b1, -1);
    checkAll("parerr");
    applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, -1);
    checkAll("parerr.sticky");

    // Framing error drops the frame; the next good frame still delivers.
    applyReset();
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1, -1);
    checkAll("frmerr");
    applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, -1);
    checkAll("frmerr.next");

    // Overrun keeps the first code, then the handshake drops valid.
    applyReset();
    rdyIdle = 1'b0;
    applyStimulus(8'h11, 1'b1, 1'b1, 1'b0, -1);
    applyStimulus(8'h22, 1'b1, 1'b1, 1'b0, -1);
    checkAll("overrun");
    code_rdy = 1'b1;
    clockEdge(1'b0, 8'h00);
    code_rdy = 1'b0;
    checkAll("overrun.accept");

    // Delivery coinciding with a handshake replaces the code without overrun.
    applyReset();
    applyStimulus(8'h11, 1'b1, 1'b1, 1'b0, -1);
    applyStimulus(8'h22, 1'b1, 1'b1, 1'b1, -1);
    checkAll("simul");

    // Reset after four data bits aborts the frame with no delivery.
    applyReset();
    rdyIdle = 1'b1;
    sendBit(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) sendBit(i[0], 1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("midrst.busy_before", 32'(busy), 32'd1);
    si = 1'b1;
    applyReset();
    checkOutput("midrst.busy_after", 32'(busy), 32'd0);
    checkOutput("midrst.vld", 32'(code_vld), 32'd0);
    applyStimulus(8'h5A, 1'b1, 1'b1, 1'b1, -1);
    checkAll("midrst.next");

`ifdef IMPCTL_DESER_MAJ_FILTER_EN
    sendBit(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("glitch.idle_busy", 32'(busy), 32'd0);
    applyStimulus(8'h96, 1'b1, 1'b1, 1'b1, 3);
    checkAll("glitch.data");
`endif

    // Randomized frames, occasional resets, random consumer readiness.
    for (int n = 0; n < 40; n++) begin
      rdyIdle = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) applyReset();
      applyStimulus(8'($urandom), ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0),
                    1'($urandom_range(0, 1)), -1);
      checkAll("rnd");
      checkOutput("rnd.busy", 32'(busy), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
